// File: rtl/bias_add_18_pkg.sv
// Shared FSM encoding, default widths/shifts and sizing helpers for the layer-18 bias-add stage.
package bias_add_18_pkg;

    // Layer-18 sizing (output channels per frame, bias coefficient width).
    localparam int unsigned KERN_S_K_18 = 16;
    localparam int unsigned COEFF_WIDTH = 16;

    // Default datapath widths and fixed-point alignment.
    localparam int unsigned DEF_PIXELS     = 64;
    localparam int unsigned DEF_ACC_W      = 32;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_BIAS_SHIFT = 8;
    localparam int unsigned DEF_OUT_SHIFT  = 8;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/bias_add_sat.sv
// Combinational bias alignment, rescale (floor shift) and saturation of one accumulator word.
// Build option BIAS_ADD_RELU_EN: negative saturated results are forced to zero.
module bias_add_sat #(
    parameter int unsigned COEFF_W    = 16,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BIAS_SHIFT = 8,
    parameter int unsigned OUT_SHIFT  = 8
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [COEFF_W-1:0] bias_i,
    output logic [DATA_W-1:0]  res_c
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned HI_W  = SUM_W - DATA_W + 1;

    logic signed [SUM_W-1:0] acc_ext_c;
    logic signed [SUM_W-1:0] bias_al_c;
    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] scaled_c;
    logic        [HI_W-1:0]  hi_c;
    logic                    ovf_c;
    logic        [DATA_W-1:0] sat_c;

    always_comb begin
        acc_ext_c = SUM_W'($signed(acc_i));
        bias_al_c = SUM_W'($signed(bias_i)) <<< BIAS_SHIFT;
        sum_c     = acc_ext_c + bias_al_c;
        scaled_c  = sum_c >>> OUT_SHIFT;

        // Representable only when every bit from the output sign upward agrees.
        hi_c  = scaled_c[SUM_W-1:DATA_W-1];
        ovf_c = ~((&hi_c) | ~(|hi_c));

        if (ovf_c) begin
            sat_c = scaled_c[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_c = scaled_c[DATA_W-1:0];
        end

`ifdef BIAS_ADD_RELU_EN
        res_c = sat_c[DATA_W-1] ? '0 : sat_c;
`else
        res_c = sat_c;
`endif
    end

endmodule

// File: rtl/bias_add_18.sv
// Layer-18 streaming bias add: one bias per output channel, added to each accumulator of that
// channel, rescaled, saturated and pushed downstream. Define BIAS_ADD_RELU_EN for a ReLU output.
module bias_add_18
    import bias_add_18_pkg::*;
#(
    parameter int unsigned KERNELS    = KERN_S_K_18,
    parameter int unsigned PIXELS     = DEF_PIXELS,
    parameter int unsigned COEFF_W    = COEFF_WIDTH,
    parameter int unsigned ACC_W      = DEF_ACC_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned BIAS_SHIFT = DEF_BIAS_SHIFT,
    parameter int unsigned OUT_SHIFT  = DEF_OUT_SHIFT
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [ACC_W-1:0]   acc_V_dout,
    input  logic               acc_V_empty_n,
    output logic               acc_V_read,
    output logic [DATA_W-1:0]  output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write,
    output logic               frame_done
);

    localparam int unsigned CH_W  = cnt_w(KERNELS);
    localparam int unsigned PIX_W = cnt_w(PIXELS);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(KERNELS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

    state_e state_q;
    state_e state_d;

    logic                en_q;
    logic [CH_W-1:0]     ch_cnt_q;
    logic [CH_W-1:0]     ch_cnt_d;
    logic [PIX_W-1:0]    pix_cnt_q;
    logic [PIX_W-1:0]    pix_cnt_d;
    logic [COEFF_W-1:0]  bias_q;
    logic [COEFF_W-1:0]  bias_d;
    logic [DATA_W-1:0]   out_q;
    logic [DATA_W-1:0]   out_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic                out_last_q;
    logic                out_last_d;

    logic                bias_rd_c;
    logic                acc_rd_c;
    logic                wr_c;
    logic                pix_last_c;
    logic                ch_last_c;
    logic [DATA_W-1:0]   res_c;

    bias_add_sat #(
        .COEFF_W    (COEFF_W),
        .ACC_W      (ACC_W),
        .DATA_W     (DATA_W),
        .BIAS_SHIFT (BIAS_SHIFT),
        .OUT_SHIFT  (OUT_SHIFT)
    ) u_sat (
        .acc_i  (acc_V_dout),
        .bias_i (bias_q),
        .res_c  (res_c)
    );

    // FSM state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one bias load, then PIXELS accumulator pops, per channel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (bias_rd_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (acc_rd_c && pix_last_c) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // FSM outputs: stream pops. en_q keeps both reads low while reset is asserted.
    always_comb begin
        bias_rd_c = 1'b0;
        acc_rd_c  = 1'b0;
        case (state_q)
            ST_LOAD: bias_rd_c = en_q & bias_V_empty_n;
            ST_RUN:  acc_rd_c  = en_q & acc_V_empty_n & (~out_valid_q | output_V_full_n);
            default: begin
                bias_rd_c = 1'b0;
                acc_rd_c  = 1'b0;
            end
        endcase
    end

    // Counters, bias latch and the single-entry output register.
    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        bias_d      = bias_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        pix_last_c = (pix_cnt_q == PIX_LAST);
        ch_last_c  = (ch_cnt_q == CH_LAST);
        wr_c       = out_valid_q & output_V_full_n;

        if (bias_rd_c) begin
            bias_d    = bias_V_dout;
            pix_cnt_d = '0;
        end

        if (acc_rd_c) begin
            pix_cnt_d = pix_last_c ? '0 : pix_cnt_q + PIX_W'(1);
            if (pix_last_c) begin
                ch_cnt_d = ch_last_c ? '0 : ch_cnt_q + CH_W'(1);
            end
            out_d       = res_c;
            out_valid_d = 1'b1;
            out_last_d  = pix_last_c & ch_last_c;
        end else if (wr_c) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            en_q        <= 1'b0;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            bias_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            en_q        <= 1'b1;
            ch_cnt_q    <= ch_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            bias_q      <= bias_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bias_V_read    = bias_rd_c;
    assign acc_V_read     = acc_rd_c;
    assign output_V_write = wr_c;
    assign output_V_din   = out_q;
    assign frame_done     = wr_c & out_last_q;

    // Bias and accumulator pops are mutually exclusive by construction of the FSM.
    assert property (@(posedge ap_clk) disable iff (!ap_rst_n) !(bias_V_read && acc_V_read));

endmodule

// File: tb/tb_bias_add_18.sv
// Bench for bias_add_18: two instances (shifts 0/0 and 8/8) on shared streams, checked against
// a frame-level arithmetic model plus hand-computed literals.
module tb_bias_add_18;

    localparam int unsigned K   = 2;
    localparam int unsigned P   = 3;
    localparam int unsigned CW  = 16;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 16;
    localparam int          NPF = K * P;
    localparam longint      SMAX = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint      SMIN = -(SMAX + 1);

    logic          ap_clk       = 1'b0;
    logic          ap_rst_n     = 1'b0;
    logic [CW-1:0] bias_dout    = '0;
    logic          bias_empty_n = 1'b0;
    logic [AW-1:0] acc_dout     = '0;
    logic          acc_empty_n  = 1'b0;
    logic          full_n       = 1'b1;

    logic                 bias_rd0, acc_rd0, wr0, fd0;
    logic                 bias_rd8, acc_rd8, wr8, fd8;
    logic signed [DW-1:0] din0, din8;

    typedef struct {
        int v0;
        int v8;
        bit last;
    } exp_t;

    exp_t eq[$];
    int   bq[$];
    int   aq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int nw      = 0;
    int n_apop  = 0;
    int pending = 0;
    int cyc_cnt = 0;
    int first_pop = 0;
    int log0 [1024];
    int log8 [1024];
    int logfd[1024];
    int wcyc [1024];
    bit pop_b = 1'b0;
    bit pop_a = 1'b0;
    bit hold_full = 1'b0;
    bit starve = 1'b0;

    always #5 ap_clk = ~ap_clk;

    bias_add_18 #(
        .KERNELS(K), .PIXELS(P), .COEFF_W(CW), .ACC_W(AW), .DATA_W(DW),
        .BIAS_SHIFT(0), .OUT_SHIFT(0)
    ) dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .bias_V_dout(bias_dout), .bias_V_empty_n(bias_empty_n), .bias_V_read(bias_rd0),
        .acc_V_dout(acc_dout), .acc_V_empty_n(acc_empty_n), .acc_V_read(acc_rd0),
        .output_V_din(din0), .output_V_full_n(full_n), .output_V_write(wr0),
        .frame_done(fd0)
    );

    bias_add_18 #(
        .KERNELS(K), .PIXELS(P), .COEFF_W(CW), .ACC_W(AW), .DATA_W(DW),
        .BIAS_SHIFT(8), .OUT_SHIFT(8)
    ) dut8 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .bias_V_dout(bias_dout), .bias_V_empty_n(bias_empty_n), .bias_V_read(bias_rd8),
        .acc_V_dout(acc_dout), .acc_V_empty_n(acc_empty_n), .acc_V_read(acc_rd8),
        .output_V_din(din8), .output_V_full_n(full_n), .output_V_write(wr8),
        .frame_done(fd8)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: exact integer sum, floor division by 2^os, clamp, optional ReLU.
    function automatic int model(input int acc, input int bias, input int bs, input int os);
        longint s;
        s = longint'(acc) + longint'(bias) * (longint'(1) <<< bs);
        s = s >>> os;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
`ifdef BIAS_ADD_RELU_EN
        if (s < 0) s = 0;
`endif
        return int'(s);
    endfunction

    task automatic push_frame(input int b0, input int b1, input int a0, input int a1,
                              input int a2, input int a3, input int a4, input int a5);
        int   a [NPF];
        int   b [K];
        exp_t e;
        a = '{a0, a1, a2, a3, a4, a5};
        b = '{b0, b1};
        for (int c = 0; c < K; c++) bq.push_back(b[c]);
        for (int i = 0; i < NPF; i++) begin
            aq.push_back(a[i]);
            e.v0   = model(a[i], b[i / P], 0, 0);
            e.v8   = model(a[i], b[i / P], 8, 8);
            e.last = (i == NPF - 1);
            eq.push_back(e);
        end
    endtask

    // Upstream FIFOs and downstream sink: commit pops, then present the next heads.
    always @(posedge ap_clk) begin
        #1;
        if (pop_b && bq.size() > 0) bq.delete(0);
        if (pop_a && aq.size() > 0) aq.delete(0);
        pop_b = 1'b0;
        pop_a = 1'b0;
        bias_empty_n = (bq.size() > 0) && (!starve || $urandom_range(0, 1) == 1);
        bias_dout    = (bq.size() > 0) ? CW'(bq[0]) : '0;
        acc_empty_n  = (aq.size() > 0) && (!starve || $urandom_range(0, 1) == 1);
        acc_dout     = (aq.size() > 0) ? AW'(aq[0]) : '0;
        full_n       = !hold_full && (!starve || $urandom_range(0, 3) != 0);
    end

    // Mid-cycle compare against the model queue on every write.
    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst_n) begin
            cyc_cnt++;
            check("read_exclusive", longint'(bias_rd0 & acc_rd0), 0);
            check("lockstep", longint'({bias_rd8, acc_rd8, wr8, fd8}),
                  longint'({bias_rd0, acc_rd0, wr0, fd0}));
            if (first_pop == 0) begin
                if (bias_rd0) first_pop = 1;
                else if (acc_rd0) first_pop = 2;
            end
            if (wr0) begin
                if (eq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got value %0d, expected no write", din0);
                end else begin
                    e = eq.pop_front();
                    check("out_shift0", longint'(din0), longint'(e.v0));
                    check("out_shift8", longint'(din8), longint'(e.v8));
                    check("frame_done", longint'(fd0), longint'(e.last));
                end
                if (nw < 1024) begin
                    log0[nw]  = int'(din0);
                    log8[nw]  = int'(din8);
                    logfd[nw] = int'(fd0);
                    wcyc[nw]  = cyc_cnt;
                end
                nw++;
                pending--;
            end else begin
                check("idle_frame_done", longint'(fd0 | fd8), 0);
            end
            if (acc_rd0) begin
                pending++;
                n_apop++;
            end
            pop_b = bias_rd0;
            pop_a = acc_rd0;
        end else begin
            pop_b = 1'b0;
            pop_a = 1'b0;
        end
    end

    task automatic cyc();
        @(negedge ap_clk);
        #2;
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (nw < target && n < budget) begin
            cyc();
            n++;
        end
        check(name, longint'(nw), longint'(target));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_bias_read"}, longint'(bias_rd0 | bias_rd8), 0);
        check({tag, "_acc_read"}, longint'(acc_rd0 | acc_rd8), 0);
        check({tag, "_write"}, longint'(wr0 | wr8), 0);
        check({tag, "_din0"}, longint'(din0), 0);
        check({tag, "_din8"}, longint'(din8), 0);
        check({tag, "_frame_done"}, longint'(fd0 | fd8), 0);
    endtask

    int lit0 [NPF];
    int lit8 [NPF];
    int base, wb, ap1, fdsum;

    initial begin
        repeat (3) cyc();
        check_quiet("reset");
        ap_rst_n = 1'b1;
        repeat (2) cyc();

        // Basic add with a full-rate frame.
        base = nw;
        push_frame(5, -2, 1, 2, 3, 10, 20, 30);
        wait_writes(base + NPF, 200, "basic_done");
        lit0 = '{6, 7, 8, 8, 18, 28};
`ifdef BIAS_ADD_RELU_EN
        lit8 = '{5, 5, 5, 0, 0, 0};
`else
        lit8 = '{5, 5, 5, -2, -2, -2};
`endif
        fdsum = 0;
        for (int i = 0; i < NPF; i++) begin
            check($sformatf("basic_lit0_%0d", i), longint'(log0[base + i]), longint'(lit0[i]));
            check($sformatf("basic_lit8_%0d", i), longint'(log8[base + i]), longint'(lit8[i]));
            fdsum += logfd[base + i];
        end
        check("basic_fd_count", longint'(fdsum), 1);
        check("basic_fd_last", longint'(logfd[base + NPF - 1]), 1);
        check("basic_burst", longint'(wcyc[base + P - 1] - wcyc[base]), longint'(P - 1));
        check("basic_span", longint'(wcyc[base + NPF - 1] - wcyc[base]), longint'(K * (P + 1) - 2));

        // Saturation and floor shift.
        base = nw;
        push_frame(0, 1, 40000, -40000, 5, -257, 0, 100);
        wait_writes(base + NPF, 200, "sat_done");
        check("sat_hi0", longint'(log0[base]), 32767);
        check("sat_hi8", longint'(log8[base]), 156);
        check("floor8_small", longint'(log8[base + 2]), 0);
`ifdef BIAS_ADD_RELU_EN
        check("sat_lo0", longint'(log0[base + 1]), 0);
        check("sat_lo8", longint'(log8[base + 1]), 0);
        check("floor0_neg", longint'(log0[base + 3]), 0);
        check("floor8_neg", longint'(log8[base + 3]), 0);
`else
        check("sat_lo0", longint'(log0[base + 1]), -32768);
        check("sat_lo8", longint'(log8[base + 1]), -157);
        check("floor0_neg", longint'(log0[base + 3]), -256);
        check("floor8_neg", longint'(log8[base + 3]), -1);
`endif

        // Backpressure for 10 cycles mid-channel.
        base = nw;
        push_frame(3, 4, 100, 200, 300, 400, 500, 600);
        push_frame(-1, -5, 7, 8, 9, 10, 11, 12);
        wait_writes(base + 1, 200, "bp_start");
        hold_full = 1'b1;
        wb = nw;
        cyc();
        ap1 = n_apop;
        repeat (9) cyc();
        check("bp_no_write", longint'(nw - wb), 0);
        check("bp_no_read", longint'(n_apop - ap1), 0);
        check("bp_pending", longint'(pending), 1);
        hold_full = 1'b0;
        wb = nw;
        repeat (2) cyc();
        check("bp_resume", longint'(nw - wb), 2);
        wait_writes(base + 2 * NPF, 300, "bp_done");

        // Random starvation on both input streams.
        starve = 1'b1;
        base = nw;
        push_frame(11, -13, -500, 0, 32000, 2, -3, 70000);
        push_frame(-128, 127, 1000, -1000, 255, 256, -255, -256);
        push_frame(300, -300, 0, 0, 0, 0, 0, 0);
        push_frame(1, 2, 3, 4, 5, 6, 7, 8);
        wait_writes(base + 4 * NPF, 3000, "starve_done");
        starve = 1'b0;
        repeat (3) cyc();

        // Asynchronous reset during channel 1.
        base = nw;
        push_frame(9, 9, 1, 1, 1, 1, 1, 1);
        push_frame(9, 9, 1, 1, 1, 1, 1, 1);
        wait_writes(base + P + 1, 300, "rst_ch1");
        #1;
        ap_rst_n = 1'b0;
        bq.delete();
        aq.delete();
        eq.delete();
        pending = 0;
        first_pop = 0;
        #1;
        check_quiet("midreset");
        repeat (3) cyc();
        ap_rst_n = 1'b1;
        base = nw;
        push_frame(7, -3, 1, 2, 3, 4, 5, 6);
        wait_writes(base + NPF, 200, "post_rst_done");
        check("post_rst_first_bias", longint'(first_pop), 1);
        check("post_rst_ch0_0", longint'(log0[base]), 8);
        check("post_rst_ch0_8", longint'(log8[base]), 7);
        check("post_rst_ch1_0", longint'(log0[base + P]), 1);
        check("post_rst_fd", longint'(logfd[base + NPF - 1]), 1);

        repeat (3) cyc();
        check("leftover_expected", longint'(eq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bias_add_18.md
# bias_add_18

Streaming bias-add stage for layer 18. Consumes the per-output-channel bias stream produced by the layer-18 bias generator and the convolution accumulator stream. For each accumulator value, adds the aligned bias of the current channel, rescales, saturates, and emits the result on an ap_fifo-style output stream toward the next layer.

## Interface
Parameters:
- KERNELS, `kern_s_k_18`: output channels per frame; one bias is read per channel.
- PIXELS, 64: accumulator values per channel (channel-major order); ≥1.
- COEFF_W, `coeff_width`: bias word width, signed.
- ACC_W, 32: accumulator word width, signed.
- DATA_W, 16: output word width, signed.
- BIAS_SHIFT, 8: left shift aligning bias to accumulator fixed point.
- OUT_SHIFT, 8: arithmetic right shift from accumulator to output fixed point.

Ports:
- ap_clk, in, 1: the single clock, rising edge.
- ap_rst_n, in, 1: asynchronous, active-low reset.
- bias_V_dout, in, COEFF_W: bias stream data.
- bias_V_empty_n, in, 1: bias stream has data.
- bias_V_read, out, 1: pops the bias stream.
- acc_V_dout, in, ACC_W: accumulator stream data.
- acc_V_empty_n, in, 1: accumulator stream has data.
- acc_V_read, out, 1: pops the accumulator stream.
- output_V_din, out, DATA_W: result data.
- output_V_full_n, in, 1: downstream can accept data.
- output_V_write, out, 1: pushes the result.
- frame_done, out, 1: one-cycle pulse on the write of the last value of a frame.

## Operation
- FSM states:
  - LOAD: bias_V_read = bias_V_empty_n. On a pop, latch the bias into bias_r, clear pix_cnt, and go to RUN.
  - RUN: pop accumulators. After the PIXELS-th pop, pix_cnt clears. If ch_cnt = KERNELS-1, ch_cnt wraps to 0; otherwise ch_cnt increments. Either way, go to LOAD.
- Accumulator read rule: acc_V_read = RUN & acc_V_empty_n & (!out_valid | output_V_full_n).
- Arithmetic:
  - sum = sext(acc, ACC_W+1) + (sext(bias_r, ACC_W+1) << BIAS_SHIFT), computed in ACC_W+1 bits.
  - Then arithmetic shift right by OUT_SHIFT (floor).
  - Then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Output register: on an accumulator pop, out_r receives the result and out_valid is set.
- Write rule: output_V_write = out_valid & output_V_full_n; output_V_din = out_r.
  - Write without a simultaneous pop: out_valid clears.
  - Write and pop in the same cycle: out_r is replaced and out_valid stays set.
- frame_done is registered alongside out_r (a last-of-frame tag). It pulses in the same cycle as the corresponding output_V_write.
- Boundary conditions:
  - output_V_full_n low: out_r holds and accumulator reads stall.
  - acc_V_empty_n low in RUN: no read; the pending out_r still drains.
  - bias_V_empty_n low in LOAD: wait; out_r still drains.
  - PIXELS = 1 is legal.
  - Extra bias entries are never read ahead.
- Reset mid-operation clears the FSM, counters, and pipeline. The partial frame is discarded and the block restarts at LOAD, channel 0.

## Timing
- Reset values: bias_V_read = 0, acc_V_read = 0, output_V_write = 0, output_V_din = 0, frame_done = 0. State LOAD; ch_cnt, pix_cnt, bias_r, out_valid all 0.
- Latency: an accumulator popped in cycle t can be written in cycle t+1.
- Throughput: 1 value/cycle within a channel, plus one bubble cycle per channel for the bias load.
- bias_V_read and acc_V_read are never asserted in the same cycle.
- A frame takes at least KERNELS·(PIXELS+1) cycles.

## Configuration
- BIAS_ADD_RELU_EN defined: negative saturated results are replaced by 0 before out_r.
- BIAS_ADD_RELU_EN undefined: signed results pass through unchanged.
- Counters, timing, and handshakes are identical in both builds.

## Structure
- Shared header bias_add_defs.vh holds:
  - the FSM state encodings (LOAD, RUN);
  - the default widths and shifts ACC_W, DATA_W, BIAS_SHIFT, OUT_SHIFT.
- KERNELS and COEFF_W come from layers_sizes.vh and my_types.vh.
- One combinational sub-module, bias_add_sat: add, shift, saturate, and optional ReLU. It is instantiated once.

## Test plan
- Basic add, KERNELS=2, PIXELS=3, BIAS_SHIFT=OUT_SHIFT=0. Biases {5, -2}, accumulators {1, 2, 3, 10, 20, 30} -> outputs {6, 7, 8, 8, 18, 28}; frame_done pulses on the 6th write only.
- Saturation with DATA_W=16. Accumulator 40000 with bias 0 -> 32767. Accumulator -40000 -> -32768. With BIAS_ADD_RELU_EN defined -> 32767 and 0.
- Shift/floor with BIAS_SHIFT=8, OUT_SHIFT=8. Bias 1, accumulator -257 -> (-257+256)>>8 = -1.
- Backpressure: hold output_V_full_n low for 10 cycles mid-channel -> exactly one value pending, no accumulator read, no loss or duplication. Release -> 1 value/cycle resumes.
- Starvation: drop acc_V_empty_n and bias_V_empty_n randomly at 50% -> output sequence matches the golden model; bias_V_read never coincides with acc_V_read.
- Reset mid-frame: assert ap_rst_n low asynchronously during channel 1 -> outputs go to 0 immediately. The next frame starts at channel 0 with a fresh bias read.
